// File: rtl/pipe_stage_reg_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pipe_stage_reg_if : upstream-in / downstream-out payload bundle        |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
interface pipe_stage_reg_if #(
  parameter int DATA_W = 32
);
  logic              valid_i;
  logic [DATA_W-1:0] data_i;
  logic              valid_o;
  logic [DATA_W-1:0] data_o;

  modport master (output valid_i, data_i, input  valid_o, data_o);
  modport slave  (input  valid_i, data_i, output valid_o, data_o);
endinterface
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pipe_stage_reg : generic pipeline stage register with flush/stall and  |
// |                  saturating hold/bubble/flush event counters           |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module pipe_stage_reg #(
  parameter int                DATA_W  = 32,
  parameter int                STALL_W = 6,
  parameter int                STAGE   = 2,
  parameter logic [DATA_W-1:0] NOP_VAL = '0,
  parameter int                CNT_W   = 16
) (
  input  wire logic               clk,
  input  wire logic               rst,
  input  wire logic [STALL_W-1:0] stall,
  input  wire logic               flush,
  input  wire logic               cnt_clr,
  pipe_stage_reg_if.slave         bus,
  output logic      [CNT_W-1:0]   hold_cnt_o,
  output logic      [CNT_W-1:0]   bubble_cnt_o,
  output logic      [CNT_W-1:0]   flush_cnt_o
);

  generate
    if ((STAGE + 1 > STALL_W - 1) || (DATA_W < 1) || (CNT_W < 2)) begin : g_param_check
      $error("pipe_stage_reg: illegal parameter combination");
    end
  endgenerate

  typedef enum logic [1:0] {
    ACT_FLUSH   = 2'd0,
    ACT_BUBBLE  = 2'd1,
    ACT_HOLD    = 2'd2,
    ACT_ADVANCE = 2'd3
  } action_t;

  action_t act;
  logic    up_stall;
  logic    dn_stall;
  logic    unused_stall;

  assign up_stall     = stall[STAGE];
  assign dn_stall     = stall[STAGE+1];
  assign unused_stall = ^stall;

  // Upstream released while downstream stalled is treated as a plain advance.
  always_comb begin
    act = ACT_ADVANCE;
    if (flush)                     act = ACT_FLUSH;
    else if (up_stall && !dn_stall) act = ACT_BUBBLE;
    else if (up_stall && dn_stall)  act = ACT_HOLD;
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.data_o  <= NOP_VAL;
      bus.valid_o <= 1'b0;
    end else begin
      case (act)
        ACT_FLUSH, ACT_BUBBLE: begin
          bus.data_o  <= NOP_VAL;
          bus.valid_o <= 1'b0;
        end
        ACT_HOLD: begin
          bus.data_o  <= bus.data_o;
          bus.valid_o <= bus.valid_o;
        end
        default: begin
          bus.data_o  <= bus.data_i;
          bus.valid_o <= bus.valid_i;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      hold_cnt_o   <= '0;
      bubble_cnt_o <= '0;
      flush_cnt_o  <= '0;
    end else begin
      if (act == ACT_HOLD)   hold_cnt_o   <= sat_inc(hold_cnt_o);
      if (act == ACT_BUBBLE) bubble_cnt_o <= sat_inc(bubble_cnt_o);
      if ((act == ACT_FLUSH) && (bus.valid_o || bus.valid_i))
        flush_cnt_o <= sat_inc(flush_cnt_o);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)
      assert (up_stall || !dn_stall)
      else $error("pipe_stage_reg: downstream stalled while upstream advances");
  end

endmodule
`default_nettype wire
